uart_rx_arbiter: RTL and testbench

Round-robin scheduler that merges the byte streams of several 80 MHz UART receivers into one ready/valid byte stream tagged with the source channel number. It sits between the per-link UART receivers and the packet parser. Each receiver presents a byte with a level valid that stays high for several cycles. This block edge-detects each valid, buffers bytes in small per-channel FIFOs, and grants the shared output fairly.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_byte_fifo.sv | 47 ++++
 rtl/uart_rx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_rx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART receive arbiter: byte width, default sizing,
// arbiter state encoding and a constant-safe ceiling log2.
package uart_arb_pkg;

    localparam int DATA_W    = 8;
    localparam int N_CH_DEF  = 4;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Per-channel byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable; a push while full is ignored unless a pop frees a slot.
module uart_byte_fifo
    import uart_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Merges N_CH edge-detected UART byte streams through per-channel FIFOs into a
// single round-robin arbitrated ready/valid stream tagged with the channel number.
module uart_rx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CH_W = clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W*N_CH-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic                     iReady,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        oData,
    output logic [CH_W-1:0]          oChan,
    output logic                     oValid,
    output logic [N_CH-1:0]          oOverflow
);

    // Returns {hit, channel}: first set bit of avail at or after start, wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] avail,
                                              input logic [CH_W-1:0] start);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_CH;
            if (avail[idx]) res = {1'b1, CH_W'(idx)};
        end
        return res;
    endfunction

    logic [N_CH-1:0]   v_d;
    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;
    logic [N_CH-1:0]   drop;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   empty;
    logic [DATA_W-1:0] fifo_dout [N_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W:0]     pick;
    logic              grant_hit;
    logic [CH_W-1:0]   grant_ch;
    logic              load;
    arb_state_t        state;
    logic [DATA_W-1:0] data_p1;
    logic [CH_W-1:0]   chan_p1;
    logic [N_CH-1:0]   ovf;

    // Stage 0: edge detect and FIFO write.
    assign push = ch_valid & ~v_d;
    assign drop = push & full & ~pop;

    for (genvar k = 0; k < N_CH; k++) begin : g_fifo
        uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (ch_data[DATA_W*k +: DATA_W]),
            .dout  (fifo_dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_d <= '0;
            ovf <= '0;
        end else begin
            v_d <= ch_valid;
            ovf <= (ovf & ~{N_CH{clr_ovf}}) | drop;
        end
    end

    // Stage 1: round-robin grant into the output register.
    assign load      = (state == ARB_IDLE) || iReady;
    assign pick      = rr_pick(~empty, rr_ptr);
    assign grant_hit = pick[CH_W];
    assign grant_ch  = pick[CH_W-1:0];

    always_comb begin
        pop = '0;
        if (load && grant_hit) pop[grant_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ARB_IDLE;
            data_p1 <= '0;
            chan_p1 <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            if (grant_hit) begin
                state   <= ARB_HOLD;
                data_p1 <= fifo_dout[grant_ch];
                chan_p1 <= grant_ch;
                rr_ptr  <= CH_W'((int'(grant_ch) + 1) % N_CH);
            end else begin
                state   <= ARB_IDLE;
            end
        end
    end

    assign oValid    = (state == ARB_HOLD);
    assign oData     = data_p1;
    assign oChan     = chan_p1;
    assign oOverflow = ovf;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Bench for uart_rx_arbiter: queue-level reference model compared every cycle,
// directed scenarios with literal beat lists, then a randomized traffic phase.
module tb_uart_rx_arbiter;

    localparam int N_CH  = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [8*N_CH-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              iReady;
    logic              clr_ovf;
    logic [7:0]        oData;
    logic [1:0]        oChan;
    logic              oValid;
    logic [N_CH-1:0]   oOverflow;

    uart_rx_arbiter #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .iReady    (iReady),
        .clr_ovf   (clr_ovf),
        .oData     (oData),
        .oChan     (oChan),
        .oValid    (oValid),
        .oOverflow (oOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int got_q[$];
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one queue per channel, rules applied in spec order.
    logic [7:0]      mq [N_CH][$];
    logic            m_valid;
    logic [7:0]      m_data;
    int              m_chan;
    int              m_rr;
    int              c;
    logic [N_CH-1:0] m_ovf;
    logic [N_CH-1:0] m_vd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_CH; k++) mq[k].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_rr    = 0;
            m_ovf   = '0;
            m_vd    = '0;
        end else begin
            if (!m_valid || iReady) begin
                m_valid = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    c = (m_rr + i) % N_CH;
                    if (!m_valid && mq[c].size() > 0) begin
                        m_valid = 1'b1;
                        m_data  = mq[c].pop_front();
                        m_chan  = c;
                    end
                end
                if (m_valid) m_rr = (m_chan + 1) % N_CH;
            end
            if (clr_ovf) m_ovf = '0;
            for (int k = 0; k < N_CH; k++) begin
                if (ch_valid[k] && !m_vd[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(ch_data[8*k +: 8]);
                    else m_ovf[k] = 1'b1;
                end
            end
            m_vd = ch_valid;
        end
    end

    // Accepted beats as seen on the DUT port, encoded chan*256 + data.
    always @(posedge clk) begin
        if (reset && oValid && iReady) got_q.push_back(int'(oChan) * 256 + int'(oData));
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("oValid", 32'(oValid), 32'(m_valid));
        if (m_valid) begin
            check("oData", 32'(oData), 32'(m_data));
            check("oChan", 32'(oChan), 32'(m_chan));
        end
        check("oOverflow", 32'(oOverflow), 32'(m_ovf));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_beats(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        ch_valid = '0;
        iReady   = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        #2 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic byte_ch(input int k, input logic [7:0] d);
        ch_data[8*k +: 8] = d;
        ch_valid[k] = 1'b1;
        tick();
        ch_valid[k] = 1'b0;
        tick();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        ch_valid = '0;
        ch_data  = '0;
        iReady   = 1'b0;
        clr_ovf  = 1'b0;
        tick();
        tick();
        check("rst_oValid", 32'(oValid), 0);
        check("rst_oData", 32'(oData), 0);
        check("rst_oChan", 32'(oChan), 0);
        check("rst_oOverflow", 32'(oOverflow), 0);
        reset = 1'b1;
        tick();

        // Single byte: two edges of latency, no repeat while valid stays high.
        got_q.delete();
        iReady = 1'b1;
        ch_data[15:8] = 8'hA5;
        ch_valid[1] = 1'b1;
        tick();
        check("lat_e0_valid", 32'(oValid), 0);
        tick();
        check("lat_e1_valid", 32'(oValid), 1);
        check("lat_e1_data", 32'(oData), 32'hA5);
        check("lat_e1_chan", 32'(oChan), 1);
        repeat (8) tick();
        ch_valid[1] = 1'b0;
        repeat (4) tick();
        exp_q.push_back(32'h1A5);
        check_beats("single");

        // Fairness: four simultaneous bytes, two rounds.
        do_reset();
        iReady  = 1'b1;
        ch_data = 32'h43322110;
        for (int r = 0; r < 2; r++) begin
            ch_valid = 4'hF;
            tick();
            ch_valid = 4'h0;
            repeat (6) tick();
            exp_q.push_back(32'h010);
            exp_q.push_back(32'h121);
            exp_q.push_back(32'h232);
            exp_q.push_back(32'h343);
        end
        check_beats("fair");

        // Back-pressure: held beat stays stable, then queued bytes follow.
        do_reset();
        byte_ch(2, 8'h55);
        check("bp_valid", 32'(oValid), 1);
        ch_data[7:0]   = 8'h66;
        ch_data[31:24] = 8'h77;
        ch_valid = 4'b1001;
        tick();
        ch_valid = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold", {21'd0, oValid, oChan, oData}, {21'd0, 1'b1, 2'd2, 8'h55});
        end
        iReady = 1'b1;
        repeat (6) tick();
        exp_q.push_back(32'h255);
        exp_q.push_back(32'h377);
        exp_q.push_back(32'h066);
        check_beats("bp");

        // Overflow: output occupied, five bytes into ch3, fifth dropped.
        do_reset();
        byte_ch(0, 8'hEE);
        for (int b = 1; b <= 5; b++) byte_ch(3, 8'(b));
        check("ovf_set", 32'(oOverflow[3]), 1);
        iReady = 1'b1;
        repeat (8) tick();
        check("ovf_sticky", 32'(oOverflow[3]), 1);
        exp_q.push_back(32'h0EE);
        for (int b = 1; b <= 4; b++) exp_q.push_back(32'h300 + b);
        check_beats("ovf");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(oOverflow), 0);

        // A drop coinciding with clr_ovf keeps the flag.
        iReady = 1'b0;
        byte_ch(0, 8'hE1);
        for (int b = 6; b <= 9; b++) byte_ch(3, 8'(b));
        ch_data[31:24] = 8'h0A;
        ch_valid[3] = 1'b1;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        ch_valid[3] = 1'b0;
        check("ovf_set_wins", 32'(oOverflow[3]), 1);
        tick();
        iReady = 1'b1;
        repeat (8) tick();
        exp_q.push_back(32'h0E1);
        for (int b = 6; b <= 9; b++) exp_q.push_back(32'h300 + b);
        check_beats("ovf2");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr2", 32'(oOverflow), 0);

        // Full FIFO with a pop in the same cycle as a new byte.
        do_reset();
        byte_ch(1, 8'h99);
        for (int b = 0; b < 4; b++) byte_ch(0, 8'hC0 + 8'(b));
        ch_data[7:0] = 8'hC4;
        ch_valid[0] = 1'b1;
        iReady = 1'b1;
        tick();
        ch_valid[0] = 1'b0;
        check("fullpop_noovf", 32'(oOverflow), 0);
        repeat (8) tick();
        exp_q.push_back(32'h199);
        for (int b = 0; b <= 4; b++) exp_q.push_back(32'h0C0 + b);
        check_beats("fullpop");

        // Reset mid-operation.
        do_reset();
        ch_data  = 32'h00302010;
        ch_valid = 4'b0111;
        tick();
        ch_valid = 4'b0000;
        tick();
        check("mid_valid_before", 32'(oValid), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_oValid", 32'(oValid), 0);
        check("mid_rst_oData", 32'(oData), 0);
        check("mid_rst_oChan", 32'(oChan), 0);
        check("mid_rst_oOverflow", 32'(oOverflow), 0);
        tick();
        reset  = 1'b1;
        iReady = 1'b1;
        got_q.delete();
        repeat (10) tick();
        check("post_rst_valid", 32'(oValid), 0);
        check_beats("post_rst");

        // Randomized traffic with alternating back-pressure phases.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_valid[k]) begin
                    if ($urandom_range(2) == 0) ch_valid[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    ch_data[8*k +: 8] = 8'($urandom);
                    ch_valid[k] = 1'b1;
                end
            end
            if ((cyc % 200) < 60) iReady = ($urandom_range(4) == 0);
            else iReady = ($urandom_range(3) != 0);
            clr_ovf = ($urandom_range(40) == 0);
            tick();
        end
        ch_valid = '0;
        clr_ovf  = 1'b0;
        iReady   = 1'b1;
        repeat (30) tick();
        check("drain_valid", 32'(oValid), 0);
        got_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
